// File: rtl/vo_pkg.sv
// Shared types and default widths for the visual-odometry stream controller.
`timescale 1ns/1ps
package vo_pkg;

    // Default coordinate and depth widths of the standard camera configuration
    localparam int VO_COOR_W  = 10;
    localparam int VO_DEPTH_W = 16;

    // Ingress frame tracking: GAP is the one-cycle frame gap after the last pixel
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } ingress_state_t;

    // Match record at the default widths; field order is the egress payload order
    typedef struct packed {
        logic [VO_COOR_W-1:0]  src_x;
        logic [VO_COOR_W-1:0]  src_y;
        logic [VO_DEPTH_W-1:0] src_depth;
        logic [VO_COOR_W-1:0]  dst_x;
        logic [VO_COOR_W-1:0]  dst_y;
        logic [VO_DEPTH_W-1:0] dst_depth;
    } match_t;

    // Egress FIFO entry: end-of-frame marker flag plus match payload
    typedef struct packed {
        logic   is_eof;
        match_t m;
    } fifo_entry_t;

endpackage

// File: rtl/vo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a slot for a push in the same cycle.
`timescale 1ns/1ps
module vo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array: written only, never reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vo_stream_ctrl.sv
// Chip-boundary stream controller: camera ingress framing and matcher egress buffering.
`timescale 1ns/1ps
module vo_stream_ctrl
    import vo_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COOR_W     = VO_COOR_W,
    parameter int DEPTH_W    = VO_DEPTH_W,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_start,
    input  logic               i_valid,
    input  logic [7:0]         i_pixel,
    input  logic [DEPTH_W-1:0] i_depth,
    output logic               o_ready,
    output logic               o_pix_valid,
    output logic               o_pix_start,
    output logic [7:0]         o_pix,
    output logic [DEPTH_W-1:0] o_pix_depth,
    output logic [COOR_W-1:0]  o_pix_x,
    output logic [COOR_W-1:0]  o_pix_y,
    input  logic               i_m_valid,
    input  logic               i_m_frame_end,
    input  logic [COOR_W-1:0]  i_m_src_x,
    input  logic [COOR_W-1:0]  i_m_src_y,
    input  logic [COOR_W-1:0]  i_m_dst_x,
    input  logic [COOR_W-1:0]  i_m_dst_y,
    input  logic [DEPTH_W-1:0] i_m_src_depth,
    input  logic [DEPTH_W-1:0] i_m_dst_depth,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic [COOR_W-1:0]  o_src_x,
    output logic [COOR_W-1:0]  o_src_y,
    output logic [COOR_W-1:0]  o_dst_x,
    output logic [COOR_W-1:0]  o_dst_y,
    output logic [DEPTH_W-1:0] o_src_depth,
    output logic [DEPTH_W-1:0] o_dst_depth,
    output logic [CNT_W-1:0]   o_match_cnt,
    output logic [CNT_W-1:0]   o_drop_cnt,
    output logic               o_frame_err
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COOR_W-1:0] X_LAST   = COOR_W'(IMG_WIDTH - 1);
    localparam logic [COOR_W-1:0] Y_LAST   = COOR_W'(IMG_HEIGHT - 1);
    localparam logic [FCNT_W-1:0] DROP_LVL = FCNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic [COOR_W-1:0]  src_x;
        logic [COOR_W-1:0]  src_y;
        logic [DEPTH_W-1:0] src_depth;
        logic [COOR_W-1:0]  dst_x;
        logic [COOR_W-1:0]  dst_y;
        logic [DEPTH_W-1:0] dst_depth;
    } match_p_t;

    typedef struct packed {
        logic     is_eof;
        match_p_t m;
    } entry_p_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---------------- Ingress ----------------
    ingress_state_t     state_q, state_d;
    logic [COOR_W-1:0]  x_q, x_d, y_q, y_d;
    logic [COOR_W-1:0]  cur_x, cur_y;
    logic               ready;
    logic               pix_valid_d, pix_start_d, ingress_err;
    logic               pix_valid_q, pix_start_q;
    logic [7:0]         pix_q;
    logic [DEPTH_W-1:0] pix_depth_q;
    logic [COOR_W-1:0]  pix_x_q, pix_y_q;

    assign ready = (state_q != GAP);

    // Next-state: pick the coordinate of the accepted pixel and advance the raster position
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cur_x       = x_q;
        cur_y       = y_q;
        pix_valid_d = 1'b0;
        pix_start_d = 1'b0;
        ingress_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && i_frame_start) begin
                    pix_valid_d = 1'b1;
                    pix_start_d = 1'b1;
                    cur_x       = '0;
                    cur_y       = '0;
                end
            end
            ACTIVE: begin
                if (i_valid) begin
                    pix_valid_d = 1'b1;
                    if (i_frame_start) begin
                        // Premature start: flag it and restart the raster
                        pix_start_d = 1'b1;
                        ingress_err = 1'b1;
                        cur_x       = '0;
                        cur_y       = '0;
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (pix_valid_d) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                if (cur_y == Y_LAST) begin
                    y_d     = '0;
                    state_d = GAP;
                end else begin
                    y_d     = cur_y + 1'b1;
                    state_d = ACTIVE;
                end
            end else begin
                x_d     = cur_x + 1'b1;
                y_d     = cur_y;
                state_d = ACTIVE;
            end
        end
    end

    // Ingress state and the one-cycle registered pixel pass-through
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            pix_valid_q <= 1'b0;
            pix_start_q <= 1'b0;
            pix_q       <= '0;
            pix_depth_q <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_valid_q <= pix_valid_d;
            pix_start_q <= pix_start_d;
            if (pix_valid_d) begin
                pix_q       <= i_pixel;
                pix_depth_q <= i_depth;
                pix_x_q     <= cur_x;
                pix_y_q     <= cur_y;
            end
        end
    end

    assign o_ready     = ready;
    assign o_pix_valid = pix_valid_q;
    assign o_pix_start = pix_start_q;
    assign o_pix       = pix_q;
    assign o_pix_depth = pix_depth_q;
    assign o_pix_x     = pix_x_q;
    assign o_pix_y     = pix_y_q;

    // ---------------- Egress ----------------
    match_p_t          in_match;
    entry_p_t          push_entry, pop_entry;
    logic              fifo_push, fifo_full, fifo_empty, room;
    logic [FCNT_W-1:0] fifo_count;
    logic              pend_q, pend_d;
    logic              match_push, match_drop, eof_push, eof_err;
    logic [CNT_W-1:0]  cur_match_q, cur_drop_q, match_cnt_q, drop_cnt_q;
    logic              frame_err_q;

    assign in_match = '{src_x: i_m_src_x, src_y: i_m_src_y, src_depth: i_m_src_depth,
                        dst_x: i_m_dst_x, dst_y: i_m_dst_y, dst_depth: i_m_dst_depth};

    // A pop in the same cycle frees a slot for the EOF marker
    assign room = !fifo_full || (i_ready && !fifo_empty);

    // Push arbitration: a match owns this cycle's slot, the EOF marker waits in pending
    always_comb begin
        push_entry = '0;
        fifo_push  = 1'b0;
        match_push = 1'b0;
        match_drop = 1'b0;
        eof_push   = 1'b0;
        eof_err    = 1'b0;
        pend_d     = pend_q;
        if (i_m_valid) begin
            // Last free slot is kept for the EOF marker
            if (fifo_count >= DROP_LVL) begin
                match_drop = 1'b1;
            end else begin
                match_push   = 1'b1;
                fifo_push    = 1'b1;
                push_entry.m = in_match;
            end
            if (i_m_frame_end) begin
                if (pend_q) eof_err = 1'b1;
                else        pend_d  = 1'b1;
            end
        end else begin
            if (pend_q && room) begin
                eof_push          = 1'b1;
                fifo_push         = 1'b1;
                push_entry.is_eof = 1'b1;
                pend_d            = 1'b0;
            end
            if (i_m_frame_end) begin
                if (pend_d) begin
                    eof_err = 1'b1;
                end else if (!eof_push && room) begin
                    eof_push          = 1'b1;
                    fifo_push         = 1'b1;
                    push_entry.is_eof = 1'b1;
                end else begin
                    pend_d = 1'b1;
                end
            end
        end
    end

    // Pending EOF, per-frame counters and the sticky error flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_q      <= 1'b0;
            cur_match_q <= '0;
            cur_drop_q  <= '0;
            match_cnt_q <= '0;
            drop_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            frame_err_q <= frame_err_q | ingress_err | eof_err;
            if (eof_push) begin
                match_cnt_q <= cur_match_q;
                drop_cnt_q  <= cur_drop_q;
                cur_match_q <= match_push ? CNT_ONE : '0;
                cur_drop_q  <= match_drop ? CNT_ONE : '0;
            end else begin
                if (match_push) cur_match_q <= sat_inc(cur_match_q);
                if (match_drop) cur_drop_q  <= sat_inc(cur_drop_q);
            end
        end
    end

    vo_sync_fifo #(
        .WIDTH ($bits(entry_p_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (fifo_push),
        .pop_i   (i_ready),
        .din_i   (push_entry),
        .dout_o  (pop_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Outputs are forced to zero while empty so idle and reset values are clean
    assign o_valid     = !fifo_empty;
    assign o_last      = !fifo_empty && pop_entry.is_eof;
    assign o_src_x     = o_valid ? pop_entry.m.src_x     : '0;
    assign o_src_y     = o_valid ? pop_entry.m.src_y     : '0;
    assign o_src_depth = o_valid ? pop_entry.m.src_depth : '0;
    assign o_dst_x     = o_valid ? pop_entry.m.dst_x     : '0;
    assign o_dst_y     = o_valid ? pop_entry.m.dst_y     : '0;
    assign o_dst_depth = o_valid ? pop_entry.m.dst_depth : '0;
    assign o_match_cnt = match_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_vo_stream_ctrl.sv
// Testbench for vo_stream_ctrl with a 4x3 frame and a 4-entry egress FIFO.
`timescale 1ns/1ps
module tb_vo_stream_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int D  = 4;
  localparam int CW = 10;
  localparam int DW = 16;
  localparam int NW = 10;
  localparam int PW = 4*CW + 2*DW;
  localparam int SAT = (1 << NW) - 1;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rst, i_frame_start, i_valid, i_m_valid, i_m_frame_end, i_ready;
  logic [7:0]    i_pixel;
  logic [DW-1:0] i_depth, i_m_src_depth, i_m_dst_depth;
  logic [CW-1:0] i_m_src_x, i_m_src_y, i_m_dst_x, i_m_dst_y;
  logic          o_ready, o_pix_valid, o_pix_start, o_valid, o_last, o_frame_err;
  logic [7:0]    o_pix;
  logic [DW-1:0] o_pix_depth, o_src_depth, o_dst_depth;
  logic [CW-1:0] o_pix_x, o_pix_y, o_src_x, o_src_y, o_dst_x, o_dst_y;
  logic [NW-1:0] o_match_cnt, o_drop_cnt;

  vo_stream_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .COOR_W(CW), .DEPTH_W(DW), .FIFO_DEPTH(D), .CNT_W(NW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_valid(i_valid),
    .i_pixel(i_pixel), .i_depth(i_depth), .o_ready(o_ready), .o_pix_valid(o_pix_valid),
    .o_pix_start(o_pix_start), .o_pix(o_pix), .o_pix_depth(o_pix_depth),
    .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .i_m_valid(i_m_valid), .i_m_frame_end(i_m_frame_end),
    .i_m_src_x(i_m_src_x), .i_m_src_y(i_m_src_y), .i_m_dst_x(i_m_dst_x), .i_m_dst_y(i_m_dst_y),
    .i_m_src_depth(i_m_src_depth), .i_m_dst_depth(i_m_dst_depth), .o_valid(o_valid),
    .i_ready(i_ready), .o_last(o_last), .o_src_x(o_src_x), .o_src_y(o_src_y),
    .o_dst_x(o_dst_x), .o_dst_y(o_dst_y), .o_src_depth(o_src_depth), .o_dst_depth(o_dst_depth),
    .o_match_cnt(o_match_cnt), .o_drop_cnt(o_drop_cnt), .o_frame_err(o_frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_gap, m_inframe, m_pend;
  int            m_pidx, cur_m, cur_d, exp_mc, exp_dc;
  logic          exp_ready, exp_pv, exp_ps, exp_err;
  logic [CW-1:0] exp_x, exp_y;
  logic [7:0]    exp_pix;
  logic [DW-1:0] exp_dep;
  logic [PW:0]   mq[$];

  wire [141:0] dut_all = {o_ready, o_pix_valid, o_pix_start, o_pix_x, o_pix_y, o_pix, o_pix_depth,
                          o_valid, o_last, o_src_x, o_src_y, o_src_depth, o_dst_x, o_dst_y,
                          o_dst_depth, o_match_cnt, o_drop_cnt, o_frame_err};
  wire [PW-1:0] dut_pay = {o_src_x, o_src_y, o_src_depth, o_dst_x, o_dst_y, o_dst_depth};

  function automatic logic [141:0] exp_all();
    logic [PW+1:0] eg;
    eg = (mq.size() > 0) ? {1'b1, mq[0]} : '0;
    return {exp_ready, exp_pv, exp_ps, exp_x, exp_y, exp_pix, exp_dep, eg,
            NW'(exp_mc), NW'(exp_dc), exp_err};
  endfunction

  function automatic int sat(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic rand_match();
    i_m_src_x = CW'($urandom); i_m_src_y = CW'($urandom);
    i_m_dst_x = CW'($urandom); i_m_dst_y = CW'($urandom);
    i_m_src_depth = DW'($urandom); i_m_dst_depth = DW'($urandom);
  endtask

  // Advance the model by the rules of the stream protocol, then clock the DUT
  task automatic tick();
    int idx, sz;
    bit emit, pop, room, ep;
    logic [PW:0] me, eof;
    if (i_rst) begin
      m_gap = 0; m_inframe = 0; m_pidx = 0; m_pend = 0;
      cur_m = 0; cur_d = 0; exp_mc = 0; exp_dc = 0; exp_err = 0;
      exp_ready = 1; exp_pv = 0; exp_ps = 0; exp_x = '0; exp_y = '0; exp_pix = '0; exp_dep = '0;
      mq.delete();
    end else begin
      emit = 0; idx = 0;
      if (i_valid && !m_gap) begin
        if (i_frame_start) begin
          if (m_inframe) exp_err = 1;
          emit = 1; idx = 0;
        end else if (m_inframe) begin
          emit = 1; idx = m_pidx;
        end
      end
      m_gap = 0;
      if (emit) begin
        exp_pv = 1; exp_ps = (idx == 0);
        exp_x = CW'(idx % W); exp_y = CW'(idx / W);
        exp_pix = i_pixel; exp_dep = i_depth;
        m_pidx = idx + 1; m_inframe = 1;
        if (idx == W*H - 1) begin m_inframe = 0; m_gap = 1; end
      end else begin
        exp_pv = 0; exp_ps = 0;
      end
      exp_ready = !m_gap;

      me  = {1'b0, i_m_src_x, i_m_src_y, i_m_src_depth, i_m_dst_x, i_m_dst_y, i_m_dst_depth};
      eof = {1'b1, {PW{1'b0}}};
      sz = mq.size();
      pop = (sz > 0) && i_ready;
      room = (sz < D) || pop;
      if (pop) void'(mq.pop_front());
      ep = 0;
      if (i_m_valid) begin
        if (D - sz <= 1) cur_d = sat(cur_d);
        else begin mq.push_back(me); cur_m = sat(cur_m); end
        if (i_m_frame_end) begin
          if (m_pend) exp_err = 1; else m_pend = 1;
        end
      end else begin
        if (m_pend && room) begin mq.push_back(eof); m_pend = 0; ep = 1; end
        if (i_m_frame_end) begin
          if (m_pend) exp_err = 1;
          else if (!ep && room) begin mq.push_back(eof); ep = 1; end
          else m_pend = 1;
        end
      end
      if (ep) begin exp_mc = cur_m; exp_dc = cur_d; cur_m = 0; cur_d = 0; end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_frame_start = 0; i_pixel = '0; i_depth = '0;
    i_m_valid = 0; i_m_frame_end = 0; i_ready = 0;
    i_m_src_x = '0; i_m_src_y = '0; i_m_dst_x = '0; i_m_dst_y = '0;
    i_m_src_depth = '0; i_m_dst_depth = '0;
  endtask

  task automatic test_reset();
    logic [141:0] rv;
    idle_inputs();
    i_rst = 1; tick(); i_rst = 0;
    rv = '0; rv[141] = 1'b1;
    checks++;
    if (dut_all !== rv) begin errors++; $display("FAIL reset_state got=%h req=%h", dut_all, rv); end
    checks++;
    if (dut_all !== exp_all()) begin errors++; $display("FAIL reset_model got=%h req=%h", dut_all, exp_all()); end
  endtask

  task automatic test_frame();
    int src, nvalid, nstart, nlow;
    src = 0; nvalid = 0; nstart = 0; nlow = 0;
    i_pixel = 8'($urandom); i_depth = DW'($urandom);
    for (int c = 0; c < 40 && src < 2*W*H; c++) begin
      bit acc;
      i_valid = 1; i_frame_start = (src % (W*H) == 0);
      acc = exp_ready;
      tick();
      checks++;
      if (dut_all !== exp_all()) begin errors++; $display("FAIL frame cyc%0d got=%h req=%h", c, dut_all, exp_all()); end
      if (o_pix_valid) nvalid++;
      if (o_pix_start) nstart++;
      if (!o_ready) nlow++;
      if (acc) begin src++; i_pixel = 8'($urandom); i_depth = DW'($urandom); end
    end
    i_valid = 0; i_frame_start = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (!o_ready) nlow++;
    end
    checks++;
    if (nvalid !== 2*W*H || nstart !== 2 || nlow !== 2) begin
      errors++; $display("FAIL frame_counts got=%0d/%0d/%0d req=%0d/2/2", nvalid, nstart, nlow, 2*W*H);
    end
    // Stray pixels with no frame start while idle
    i_valid = 1; i_frame_start = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (o_pix_valid !== 1'b0 || o_frame_err !== 1'b0 || dut_all !== exp_all()) begin
        errors++; $display("FAIL stray_idle got=%h req=%h", dut_all, exp_all());
      end
    end
    i_valid = 0;
    tick();
  endtask

  task automatic test_frame_err();
    for (int k = 0; k < 17; k++) begin
      i_valid = 1; i_frame_start = (k == 0 || k == 5);
      i_pixel = 8'($urandom); i_depth = DW'($urandom);
      tick();
      checks++;
      if (dut_all !== exp_all()) begin errors++; $display("FAIL ferr cyc%0d got=%h req=%h", k, dut_all, exp_all()); end
      if (k == 5) begin
        checks++;
        if ({o_frame_err, o_pix_start, o_pix_x, o_pix_y} !== {1'b1, 1'b1, 20'd0}) begin
          errors++; $display("FAIL ferr_restart got=%b %b %0d %0d req=1 1 0 0", o_frame_err, o_pix_start, o_pix_x, o_pix_y);
        end
      end
    end
    checks++;
    if ({o_pix_x, o_pix_y, o_ready} !== {CW'(W-1), CW'(H-1), 1'b0}) begin
      errors++; $display("FAIL ferr_end got=%0d,%0d rdy=%b req=%0d,%0d rdy=0", o_pix_x, o_pix_y, o_ready, W-1, H-1);
    end
    i_valid = 0; i_frame_start = 0;
    tick(); tick();
  endtask

  task automatic test_ingress_random();
    for (int c = 0; c < 150; c++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_frame_start = ($urandom_range(0, 9) == 0);
      i_pixel = 8'($urandom); i_depth = DW'($urandom);
      tick();
      checks++;
      if (dut_all !== exp_all()) begin errors++; $display("FAIL ing_rand cyc%0d got=%h req=%h", c, dut_all, exp_all()); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_match_eof();
    int xf;
    logic last_l;
    xf = 0; last_l = 0;
    i_ready = 1;
    for (int c = 0; c < 9; c++) begin
      if (o_valid && i_ready) begin xf++; last_l = o_last; end
      i_m_valid = (c < 3); i_m_frame_end = (c == 2);
      rand_match();
      tick();
      checks++;
      if (dut_all !== exp_all()) begin errors++; $display("FAIL m_eof cyc%0d got=%h req=%h", c, dut_all, exp_all()); end
    end
    i_m_valid = 0; i_m_frame_end = 0;
    checks++;
    if (xf !== 4 || last_l !== 1'b1 || o_match_cnt !== NW'(3) || o_drop_cnt !== NW'(0)) begin
      errors++; $display("FAIL m_eof_summary got xf=%0d last=%b mc=%0d dc=%0d req xf=4 last=1 mc=3 dc=0", xf, last_l, o_match_cnt, o_drop_cnt);
    end
  endtask

  task automatic test_drop();
    int xf;
    xf = 0;
    for (int c = 0; c < 16; c++) begin
      i_ready = (c >= 8);
      if (o_valid && i_ready) xf++;
      i_m_valid = (c < 6); i_m_frame_end = (c == 6);
      rand_match();
      tick();
      checks++;
      if (dut_all !== exp_all()) begin errors++; $display("FAIL drop cyc%0d got=%h req=%h", c, dut_all, exp_all()); end
    end
    i_m_valid = 0; i_m_frame_end = 0;
    checks++;
    if (xf !== 4 || o_match_cnt !== NW'(3) || o_drop_cnt !== NW'(3)) begin
      errors++; $display("FAIL drop_summary got xf=%0d mc=%0d dc=%0d req xf=4 mc=3 dc=3", xf, o_match_cnt, o_drop_cnt);
    end
  endtask

  task automatic test_toggle();
    logic [PW-1:0] sent[$];
    logic [PW-1:0] held;
    bit stalled;
    int nrx, bad_order, bad_hold;
    nrx = 0; bad_order = 0; bad_hold = 0; stalled = 0; held = '0;
    for (int c = 0; c < 28; c++) begin
      i_ready = (c % 2 == 0);
      if (stalled && dut_pay !== held) bad_hold++;
      if (o_valid && i_ready && !o_last) begin
        if (sent.size() == 0 || dut_pay !== sent[0]) bad_order++;
        if (sent.size() > 0) void'(sent.pop_front());
        nrx++;
      end
      stalled = o_valid && !i_ready;
      held = dut_pay;
      i_m_valid = (c < 20) && (c % 2 == 0);
      i_m_frame_end = (c == 21);
      rand_match();
      if (i_m_valid) sent.push_back({i_m_src_x, i_m_src_y, i_m_src_depth, i_m_dst_x, i_m_dst_y, i_m_dst_depth});
      tick();
      checks++;
      if (dut_all !== exp_all()) begin errors++; $display("FAIL toggle cyc%0d got=%h req=%h", c, dut_all, exp_all()); end
    end
    i_m_valid = 0; i_m_frame_end = 0;
    checks++;
    if (nrx !== 10 || bad_order !== 0 || bad_hold !== 0 || o_match_cnt !== NW'(10) || o_drop_cnt !== NW'(0)) begin
      errors++; $display("FAIL toggle_summary got rx=%0d order=%0d hold=%0d mc=%0d dc=%0d req 10 0 0 10 0",
                         nrx, bad_order, bad_hold, o_match_cnt, o_drop_cnt);
    end
  endtask

  task automatic test_egress_random();
    for (int c = 0; c < 200; c++) begin
      i_m_valid = ($urandom_range(0, 1) == 1);
      i_m_frame_end = ($urandom_range(0, 9) == 0);
      i_ready = ($urandom_range(0, 9) < 6);
      rand_match();
      tick();
      checks++;
      if (dut_all !== exp_all()) begin errors++; $display("FAIL eg_rand cyc%0d got=%h req=%h", c, dut_all, exp_all()); end
    end
    idle_inputs();
    i_ready = 1;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (dut_all !== exp_all()) begin errors++; $display("FAIL eg_rand_drain got=%h req=%h", dut_all, exp_all()); end
  endtask

  task automatic test_reset_mid();
    logic [141:0] rv;
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      i_valid = 1; i_frame_start = (c == 0); i_pixel = 8'($urandom); i_depth = DW'($urandom);
      i_m_valid = (c < 2); rand_match();
      tick();
    end
    i_rst = 1; i_m_valid = 1;
    tick();
    i_rst = 0;
    idle_inputs();
    rv = '0; rv[141] = 1'b1;
    checks++;
    if (dut_all !== rv) begin errors++; $display("FAIL reset_mid got=%h req=%h", dut_all, rv); end
    // Following frame on both sides
    i_ready = 1;
    for (int c = 0; c < 16; c++) begin
      i_valid = (c < W*H); i_frame_start = (c == 0);
      i_pixel = 8'($urandom); i_depth = DW'($urandom);
      i_m_valid = (c < 3); i_m_frame_end = (c == 2); rand_match();
      tick();
      checks++;
      if (dut_all !== exp_all()) begin errors++; $display("FAIL post_reset cyc%0d got=%h req=%h", c, dut_all, exp_all()); end
    end
    checks++;
    if (o_match_cnt !== NW'(3) || o_drop_cnt !== NW'(0) || o_frame_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_stats got mc=%0d dc=%0d err=%b req 3 0 0", o_match_cnt, o_drop_cnt, o_frame_err);
    end
  endtask

  initial begin
    i_rst = 1;
    idle_inputs();
    test_reset();
    test_frame();
    test_frame_err();
    test_ingress_random();
    test_match_eof();
    test_drop();
    test_toggle();
    test_egress_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
